// File: rtl/pwm_level_multi_if.sv
// pwm_level_multi_if: control and status bundle for the multi-channel PWM level generator.
interface pwm_level_multi_if #(
    parameter int CHANNELS = 2,
    parameter int WIDTH = 8
);
    logic enable;
    logic ramp_en;
    logic [CHANNELS-1:0] load;
    logic [CHANNELS*WIDTH-1:0] level_in;
    logic [CHANNELS-1:0] pwm_out;
    logic [CHANNELS*WIDTH-1:0] level_cur;
    logic cycle_start;
    logic busy;
    modport master (
        output enable, ramp_en, load, level_in,
        input pwm_out, level_cur, cycle_start, busy
    );
    modport slave (
        input enable, ramp_en, load, level_in,
        output pwm_out, level_cur, cycle_start, busy
    );
endinterface

// File: rtl/pwm_level_multi.sv
// pwm_level_multi: multi-channel PWM with prescaler, period-boundary level updates, optional ramping and phase stagger.
module pwm_level_multi #(
    parameter int CHANNELS = 2,
    parameter int WIDTH = 8,
    parameter int PRESCALE = 1,
    parameter int RAMP_STEP = 16,
    parameter int STAGGER = 0
) (
    input logic clock,
    input logic nreset,
    pwm_level_multi_if.slave bus
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam int OFFS = (1 << WIDTH) / CHANNELS;
    localparam logic [WIDTH-1:0] STEP = WIDTH'(RAMP_STEP);
    logic [PW-1:0] presc_q, presc_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [CHANNELS-1:0][WIDTH-1:0] tgt_q, tgt_d, cur_q, cur_d, diff, stepped, ph;
    logic [CHANNELS-1:0] pwm_q, pwm_d, up;
    logic cs_q, busy_q, busy_d, tick, boundary;
    always_comb begin
        tick = presc_q == PW'(PRESCALE - 1);
        boundary = tick && (&cnt_q);
        presc_d = tick ? '0 : presc_q + PW'(1);
        cnt_d = tick ? cnt_q + WIDTH'(1) : cnt_q;
        busy_d = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            tgt_d[i] = bus.load[i] ? bus.level_in[i*WIDTH +: WIDTH] : tgt_q[i];
            up[i] = tgt_q[i] > cur_q[i];
            diff[i] = up[i] ? tgt_q[i] - cur_q[i] : cur_q[i] - tgt_q[i];
            // step is clamped to the remaining distance, so it never overshoots or wraps
            stepped[i] = up[i] ? cur_q[i] + (diff[i] < STEP ? diff[i] : STEP)
                               : cur_q[i] - (diff[i] < STEP ? diff[i] : STEP);
            cur_d[i] = !boundary ? cur_q[i] : bus.ramp_en ? stepped[i] : tgt_q[i];
            ph[i] = cnt_q + WIDTH'(STAGGER * i * OFFS);
            pwm_d[i] = ph[i] < cur_q[i];
            busy_d = busy_d | (cur_q[i] != tgt_q[i]);
        end
    end
    always_ff @(posedge clock) begin
        if (!nreset) begin
            presc_q <= '0;
            cnt_q <= '0;
            tgt_q <= '0;
            cur_q <= '0;
            pwm_q <= '0;
            cs_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            presc_q <= bus.enable ? presc_d : '0;
            cnt_q <= bus.enable ? cnt_d : '0;
            tgt_q <= tgt_d;
            cur_q <= bus.enable ? cur_d : '0;
            pwm_q <= bus.enable ? pwm_d : '0;
            cs_q <= bus.enable && boundary;
            busy_q <= busy_d;
        end
    end
    assign bus.pwm_out = pwm_q;
    assign bus.level_cur = cur_q;
    assign bus.cycle_start = cs_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_pwm_level_multi.sv
// tb_pwm_level_multi: random stimulus on two configurations checked every clock against a time-based reference model.
module tb_pwm_level_multi;
    logic clk = 1'b0;
    logic nreset = 1'b0;
    logic enable = 1'b0;
    logic ramp_en = 1'b0;
    logic [1:0] load = '0;
    logic [15:0] level_in = '0;
    int checks = 0;
    int errs = 0;
    always #5 clk = ~clk;

    pwm_level_multi_if #(.CHANNELS(2), .WIDTH(8)) b0 ();
    pwm_level_multi_if #(.CHANNELS(2), .WIDTH(8)) b1 ();
    assign b0.enable = enable;
    assign b0.ramp_en = ramp_en;
    assign b0.load = load;
    assign b0.level_in = level_in;
    assign b1.enable = enable;
    assign b1.ramp_en = ramp_en;
    assign b1.load = load;
    assign b1.level_in = level_in;

    pwm_level_multi #(.CHANNELS(2), .WIDTH(8), .PRESCALE(1), .RAMP_STEP(16), .STAGGER(0))
        u0 (.clock(clk), .nreset(nreset), .bus(b0.slave));
    pwm_level_multi #(.CHANNELS(2), .WIDTH(8), .PRESCALE(4), .RAMP_STEP(48), .STAGGER(1))
        u1 (.clock(clk), .nreset(nreset), .bus(b1.slave));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Reference: clocks since enable give cnt and boundaries by plain division.
    int pr[2] = '{1, 4};
    int st[2] = '{0, 1};
    int rs[2] = '{16, 48};
    int mt[2];
    int tgt[2][2];
    int cur[2][2];
    bit e_pwm[2][2];
    bit e_cs[2];
    bit e_busy[2];
    int m_cnt, m_d;
    bit m_bnd;
    initial begin
        for (int k = 0; k < 2; k++) begin
            mt[k] = 0; e_cs[k] = 0; e_busy[k] = 0;
            for (int i = 0; i < 2; i++) begin
                tgt[k][i] = 0; cur[k][i] = 0; e_pwm[k][i] = 0;
            end
        end
    end
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!nreset) begin
                mt[k] = 0; e_cs[k] = 0; e_busy[k] = 0;
                for (int i = 0; i < 2; i++) begin
                    tgt[k][i] = 0; cur[k][i] = 0; e_pwm[k][i] = 0;
                end
            end else begin
                m_cnt = (mt[k] / pr[k]) % 256;
                m_bnd = (mt[k] % pr[k] == pr[k] - 1) && m_cnt == 255;
                e_busy[k] = (cur[k][0] != tgt[k][0]) || (cur[k][1] != tgt[k][1]);
                e_cs[k] = enable && m_bnd;
                for (int i = 0; i < 2; i++) begin
                    e_pwm[k][i] = enable && (((m_cnt + st[k] * i * 128) % 256) < cur[k][i]);
                    if (!enable) cur[k][i] = 0;
                    else if (m_bnd) begin
                        m_d = tgt[k][i] - cur[k][i];
                        if (ramp_en) m_d = m_d > rs[k] ? rs[k] : (m_d < -rs[k] ? -rs[k] : m_d);
                        cur[k][i] = cur[k][i] + m_d;
                    end
                    if (load[i]) tgt[k][i] = int'(level_in[i*8 +: 8]);
                end
                mt[k] = enable ? mt[k] + 1 : 0;
            end
        end
    end

    bit run = 1'b0;
    always @(negedge clk) begin
        if (run) begin
            check("pwm0", 32'(b0.pwm_out), 32'({e_pwm[0][1], e_pwm[0][0]}));
            check("lvl0", 32'(b0.level_cur), 32'({8'(cur[0][1]), 8'(cur[0][0])}));
            check("cs0", 32'(b0.cycle_start), 32'(e_cs[0]));
            check("busy0", 32'(b0.busy), 32'(e_busy[0]));
            check("pwm1", 32'(b1.pwm_out), 32'({e_pwm[1][1], e_pwm[1][0]}));
            check("lvl1", 32'(b1.level_cur), 32'({8'(cur[1][1]), 8'(cur[1][0])}));
            check("cs1", 32'(b1.cycle_start), 32'(e_cs[1]));
            check("busy1", 32'(b1.busy), 32'(e_busy[1]));
        end
    end

    function automatic logic [7:0] pick();
        case ($urandom_range(0, 5))
            0: return 8'h00;
            1: return 8'hFF;
            2: return 8'h40;
            3: return 8'h80;
            4: return 8'h78;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    int hi0, hi1, seg;
    bit seen;
    initial begin
        run = 1'b1;
        repeat (3) @(negedge clk);
        nreset = 1'b1;
        enable = 1'b1;
        load = 2'b11;
        level_in = {8'hFF, 8'h40};
        @(negedge clk);
        load = '0;
        seen = 1'b0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            @(negedge clk);
            seen = b0.cycle_start;
        end
        check("cs_wait", 32'(seen), 32'd1);
        hi0 = 0;
        hi1 = 0;
        repeat (256) begin
            @(negedge clk);
            hi0 += int'(b0.pwm_out[0]);
            hi1 += int'(b0.pwm_out[1]);
        end
        check("duty40", 32'(hi0), 32'd64);
        check("dutyFF", 32'(hi1), 32'd255);
        repeat (30) begin
            seg = $urandom_range(200, 1500);
            ramp_en = 1'($urandom_range(0, 1));
            for (int c = 0; c < seg; c++) begin
                @(negedge clk);
                load = '0;
                nreset = $urandom_range(0, 2999) != 0;
                if ($urandom_range(0, 999) < 4) begin
                    load = 2'($urandom_range(1, 3));
                    level_in = {pick(), pick()};
                end
                if (enable) enable = $urandom_range(0, 999) >= 2;
                else enable = $urandom_range(0, 99) < 10;
            end
        end
        @(negedge clk);
        run = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
